freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 18 +
 rtl/signal_sync.sv | 39 +++
 rtl/freq_meter.sv | 150 +++++++++++++++
 tb/tb_freq_meter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared definitions for the frequency meter.
//   state_t              - measurement FSM states (IDLE, FLUSH, GATE)
//   DEF_GATE_CYCLES      - default gate window length in clk cycles
//   DEF_CNT_W            - default edge-count result width
//   DEF_SYNC_STAGES      - default synchronizer depth for the measured signal
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_GATE  = 2'd2
  } state_t;

  localparam int unsigned DEF_GATE_CYCLES = 1000000;
  localparam int unsigned DEF_CNT_W       = 24;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/signal_sync.sv
// signal_sync: multi-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk      - sampling clock (rising edge)
//   rst      - asynchronous active-high reset, clears all flops
//   async_in - asynchronous input signal
//   flush    - suppresses edge_out; the history flop still tracks the
//              synchronized level so a level already high is not an edge
//   edge_out - one-cycle pulse on a synchronized rising edge
module signal_sync
  import freq_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic flush,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= w_synced;
    end
  end

  assign edge_out = w_synced & ~r_prev & ~flush;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous signal over a fixed
// gate window of GATE_CYCLES clk cycles, back to back while enabled.
// Ports:
//   clk         - sole clock, rising edge
//   rst         - asynchronous active-high reset
//   enable      - high: measure continuously; low: idle
//   sig_in      - asynchronous measured signal
//   freq_count  - edges counted in the last completed window
//   count_valid - one-cycle pulse when freq_count updates
//   overflow    - last completed window saturated the counter
//   busy        - a window (or its pipeline flush) is in progress
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  // Timer is shared between the flush phase and the gate window.
  localparam int unsigned TMR_SPAN = (GATE_CYCLES > SYNC_STAGES + 1) ? GATE_CYCLES : SYNC_STAGES + 1;
  localparam int unsigned TMR_W    = $clog2(TMR_SPAN);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_sat, w_sat_nxt;
  logic [CNT_W-1:0] r_freq_count;
  logic             r_count_valid;
  logic             r_overflow;

  logic             w_edge;
  logic             w_flush;
  logic             w_at_max;
  logic             w_report;
  logic [CNT_W-1:0] w_final_cnt;
  logic             w_final_sat;

  assign w_flush = (r_state != ST_GATE);

  signal_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .flush    (w_flush),
    .edge_out (w_edge)
  );

  // Count including the edge of the current cycle, saturating at CNT_MAX.
  assign w_at_max    = (r_cnt == CNT_MAX);
  assign w_final_cnt = (w_edge && !w_at_max) ? r_cnt + 1'b1 : r_cnt;
  assign w_final_sat = r_sat | (w_edge & w_at_max);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_cnt_nxt   = r_cnt;
    w_sat_nxt   = r_sat;
    w_report    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        w_cnt_nxt   = '0;
        w_sat_nxt   = 1'b0;
        if (enable) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_cnt_nxt = '0;
        w_sat_nxt = 1'b0;
        if (!enable) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == FLUSH_LAST) begin
          w_state_nxt = ST_GATE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_GATE: begin
        if (r_timer == TMR_LAST) begin
          // Terminal cycle reports even if enable drops on it; the next
          // window starts on the following cycle without a dead cycle.
          w_report    = 1'b1;
          w_timer_nxt = '0;
          w_cnt_nxt   = '0;
          w_sat_nxt   = 1'b0;
          if (!enable) w_state_nxt = ST_IDLE;
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
          w_cnt_nxt   = '0;
          w_sat_nxt   = 1'b0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          w_cnt_nxt   = w_final_cnt;
          w_sat_nxt   = w_final_sat;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_cnt_nxt   = '0;
        w_sat_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_cnt         <= '0;
      r_sat         <= 1'b0;
      r_freq_count  <= '0;
      r_count_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sat         <= w_sat_nxt;
      r_count_valid <= w_report;
      if (w_report) begin
        r_freq_count <= w_final_cnt;
        r_overflow   <= w_final_sat;
      end
    end
  end

  assign freq_count  = r_freq_count;
  assign count_valid = r_count_valid;
  assign overflow    = r_overflow;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: self-checking bench for freq_meter (GATE_CYCLES=100,
// CNT_W=5, SYNC_STAGES=2). Expected window results are queued when the
// stimulus for a window is set up and checked on each count_valid pulse.
module tb_freq_meter;

  localparam int unsigned CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] freq_count;
  logic             count_valid;
  logic             overflow;
  logic             busy;

  freq_meter #(
    .GATE_CYCLES(100),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sig_in      (sig_in),
    .freq_count  (freq_count),
    .count_valid (count_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  typedef struct {
    int unsigned cnt;
    bit          ovf;
    bit          chk;   // 0: window straddles a stimulus change, not checked
  } exp_t;

  typedef struct {
    int unsigned per;
    int unsigned n;
    int unsigned cnt;
    bit          ovf;
  } row_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  // sig_in generator: drv_per==0 holds drv_lvl, else square wave of drv_per.
  int unsigned drv_per = 0;
  bit          drv_lvl = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int unsigned phase;
    phase  = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (drv_per == 0) begin
        sig_in = drv_lvl;
      end else begin
        phase  = (phase + 1 >= drv_per) ? 0 : phase + 1;
        sig_in = (phase < drv_per / 2);
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (count_valid) begin
        chk("valid_not_back_to_back", prev, 0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got count=%0d expected no pulse at %0t", freq_count, $time);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            chk("freq_count", freq_count, e.cnt);
            chk("overflow", overflow, e.ovf);
          end
        end
      end
      prev = count_valid;
    end
  end

  task automatic push(input int unsigned cnt, input bit ovf, input bit c);
    exp_t e;
    e.cnt = cnt;
    e.ovf = ovf;
    e.chk = c;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int unsigned budget);
    bit got;
    got = 1'b0;
    for (int unsigned c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (count_valid) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got no pulse expected one within %0d cycles", budget);
    end
  endtask

  // Single rising edge placed 'off' cycles after the reference pulse edge.
  task automatic single_edge(input int unsigned off, input int unsigned e1, input int unsigned e2);
    drv_lvl = 1'b0;
    push(0, 0, 0);
    wait_valid(250);
    push(0, 0, 1);
    wait_valid(250);
    push(e1, 0, 1);
    push(e2, 0, 1);
    repeat (off - 1) @(posedge clk);
    @(negedge clk);
    drv_lvl = 1'b1;
    wait_valid(250);
    wait_valid(250);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected one before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t        rows[5];
    int unsigned n;
    bit          found;

    rows[0] = '{per: 10, n: 3, cnt: 10, ovf: 1'b0};
    rows[1] = '{per: 2,  n: 2, cnt: 31, ovf: 1'b1};
    rows[2] = '{per: 10, n: 2, cnt: 10, ovf: 1'b0};
    rows[3] = '{per: 4,  n: 2, cnt: 25, ovf: 1'b0};
    rows[4] = '{per: 5,  n: 1, cnt: 20, ovf: 1'b0};

    rst    = 1'b1;
    enable = 1'b0;
    #2;
    chk("rst_freq_count", freq_count, 0);
    chk("rst_count_valid", count_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Periodic inputs: every fully covered window has a fixed count.
    drv_per = 10;
    enable  = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_enable", busy, 1);
    foreach (rows[i]) begin
      drv_per = rows[i].per;
      push(0, 0, 0);
      for (int unsigned k = 0; k < rows[i].n; k++) push(rows[i].cnt, rows[i].ovf, 1);
      repeat (rows[i].n + 1) wait_valid(250);
    end

    // enable dropped at cycle 50 of a window.
    drv_per = 10;
    push(0, 0, 0);
    push(10, 0, 1);
    wait_valid(250);
    wait_valid(250);
    repeat (49) @(posedge clk);
    #1;
    chk("busy_mid_window", busy, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_after_disable", busy, 0);
    chk("hold_freq_count", freq_count, 10);
    chk("hold_overflow", overflow, 0);
    repeat (150) @(posedge clk);
    chk("idle_busy", busy, 0);

    // Asynchronous reset pulse mid-window.
    @(negedge clk);
    enable = 1'b1;
    repeat (60) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_freq_count", freq_count, 0);
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", count_valid, 0);
    #4;
    rst = 1'b0;
    push(10, 0, 1);
    n     = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (count_valid) found = 1'b1;
    end
    chk("post_rst_valid_seen", found, 1);
    chk("post_rst_latency_ge_103", (n >= 103) ? 1 : 0, 1);

    // Level already high before enable is never an edge.
    @(negedge clk);
    enable  = 1'b0;
    drv_per = 0;
    drv_lvl = 1'b1;
    repeat (20) @(posedge clk);
    push(0, 0, 1);
    push(0, 0, 1);
    @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("static_high_busy", busy, 0);

    // Edge sampled on the terminal cycle vs. the cycle after it.
    @(negedge clk);
    drv_lvl = 1'b0;
    enable  = 1'b1;
    single_edge(97, 1, 0);
    single_edge(98, 0, 1);

    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
